// File: rtl/aes_pkg.sv
// Shared AES/Rijndael definitions: byte type, legal block widths, row offsets.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package aes_pkg;

  typedef logic [7:0] byte_t;

  // Rijndael state widths supported by the ShiftRows datapath.
  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Cyclic left-shift amount of row r for an NB-column state.
  // NB 4 and 6 use {0,1,2,3}; NB 8 widens the lower rows to {0,1,3,4}.
  function automatic int row_off(input int nb, input int r);
    if ((nb == 8) && (r >= 2)) begin
      return r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// ShiftRows / InvShiftRows byte permutation for an NB-column Rijndael state.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure wiring plus one 2:1 mux per byte.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              inv,
  input  logic [0:32*NB-1]  data_in,
  output logic [0:32*NB-1]  data_out
);

  // Byte k sits at bits [8k +: 8], row k%4, column k/4. Every output byte
  // picks from one of two fixed source bytes, so the whole permutation is
  // static routing selected per block by inv.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF   = row_off(NB, r);
      localparam int FWD_C = (c + OFF) % NB;
      localparam int INV_C = (c - OFF + NB) % NB;

      byte_t fwd_b;
      byte_t inv_b;

      assign fwd_b = data_in[8*(4*FWD_C + r) +: 8];
      assign inv_b = data_in[8*(4*INV_C + r) +: 8];
      assign data_out[8*(4*c + r) +: 8] = inv ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows/InvShiftRows with valid/ready handshake and flush.
// Latency: STAGES cycles from acceptance to out_valid; one block per cycle at full flow.
// Backpressure: ready ripples back combinationally; a stalled stage holds its block.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_inv,
  input  logic [0:32*NB-1]              data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:32*NB-1]              data_out,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int W     = 32 * NB;
  localparam int OCC_W = $clog2(STAGES + 1);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end

  logic [0:W-1]        perm_dat;
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   valid_d;
  logic [0:W-1]        data_q [STAGES];
  logic [0:W-1]        data_d [STAGES];
  logic [STAGES-1:0]   adv;
  logic                hole;
  logic [STAGES-1:0]   src_vld;
  logic [0:W-1]        src_dat [STAGES];

  // The mode bit only steers the permutation mux, so it travels with the
  // block implicitly: the registered data is already permuted.
  shift_rows_perm #(.NB(NB)) u_perm (
    .inv      (in_inv),
    .data_in  (data_in),
    .data_out (perm_dat)
  );

  // Each stage is fed by the stage before it; stage 0 by the permuted input.
  assign src_vld[0] = in_valid;
  assign src_dat[0] = perm_dat;
  for (genvar g = 1; g < STAGES; g++) begin : g_src
    assign src_vld[g] = valid_q[g-1];
    assign src_dat[g] = data_q[g-1];
  end

  // Stage i can take a new value if any stage from i to the output is
  // empty, or the output is draining this cycle.
  always_comb begin
    adv  = '0;
    hole = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hole   = hole || !valid_q[i];
      adv[i] = hole;
    end
  end

  // Next-state: advancing stages take their source, stalled stages hold;
  // flush empties every stage and blocks the incoming transfer.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = data_q[i];
      if (adv[i]) begin
        valid_d[i] = src_vld[i];
        if (src_vld[i] && !flush) begin
          data_d[i] = src_dat[i];
        end
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Stage registers; reset discards every in-flight block and zeroes data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

  // Held low while reset is asserted so nothing is accepted into a clearing pipe.
  assign in_ready  = adv[0] && !flush && rst_n;
  assign out_valid = valid_q[STAGES-1];
  assign data_out  = data_q[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: NB=4, STAGES=1 (vector table, stall) ----------------
  logic a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [0:127] a_din, a_dout;
  logic [0:0]   a_occ;
  shift_rows_pipe #(.NB(4), .STAGES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_inv(a_in_inv), .data_in(a_din),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_dout),
    .occupancy(a_occ));

  // ---------------- DUT B: NB=4, STAGES=3 (latency, backpressure stream) -------
  logic b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [0:127] b_din, b_dout;
  logic [1:0]   b_occ;
  shift_rows_pipe #(.NB(4), .STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_inv(b_in_inv), .data_in(b_din),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_dout),
    .occupancy(b_occ));

  // ---------------- DUT C: NB=4, STAGES=2 (flush, reset) -----------------------
  logic c_flush, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [0:127] c_din, c_dout;
  logic [1:0]   c_occ;
  shift_rows_pipe #(.NB(4), .STAGES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_inv(c_in_inv), .data_in(c_din),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .data_out(c_dout),
    .occupancy(c_occ));

  // ---------------- DUT F -> DUT I: NB=8 forward then inverse ------------------
  logic f_flush, f_in_valid, f_in_ready, f_in_inv, f_out_valid;
  logic i_in_ready, i_out_valid, i_out_ready, i_in_inv;
  logic [0:255] f_din, f_dout, i_dout;
  logic [0:0]   f_occ, i_occ;
  shift_rows_pipe #(.NB(8), .STAGES(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .in_valid(f_in_valid),
    .in_ready(f_in_ready), .in_inv(f_in_inv), .data_in(f_din),
    .out_valid(f_out_valid), .out_ready(i_in_ready), .data_out(f_dout),
    .occupancy(f_occ));
  shift_rows_pipe #(.NB(8), .STAGES(1)) dut_i (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .in_valid(f_out_valid),
    .in_ready(i_in_ready), .in_inv(i_in_inv), .data_in(f_dout),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .data_out(i_dout),
    .occupancy(i_occ));

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ShiftRows built from the row-offset table written out by hand.
  function automatic logic [0:255] model(input int nb, input logic inv, input logic [0:255] d);
    logic [0:255] o;
    int off;
    int sc;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      case (r)
        0:       off = 0;
        1:       off = 1;
        2:       off = (nb == 8) ? 3 : 2;
        default: off = (nb == 8) ? 4 : 3;
      endcase
      for (int c = 0; c < nb; c++) begin
        sc = inv ? ((c - off + nb) % nb) : ((c + off) % nb);
        o[8*(4*c + r) +: 8] = d[8*(4*sc + r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] model4(input logic inv, input logic [0:127] d);
    logic [0:255] t;
    t = model(4, inv, {d, 128'h0});
    return t[0:127];
  endfunction

  typedef struct {
    logic         inv;
    logic [0:127] din;
    logic [0:127] exp;
  } vec_t;

  vec_t         vecs [7];
  logic [0:127] blk  [20];
  logic [0:255] blk8 [6];
  logic [0:127] exp_q [$];
  logic [0:255] src_q [$];
  logic [0:255] orig_q [$];
  logic [0:127] e4;
  logic [0:255] e8;
  logic         fin, fmid, fout;
  int           sent, recv, inflight, cyc, lat;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-computed vectors: counting block, FIPS-197 round 1, single-byte markers.
    vecs[0] = '{1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h00050A0F04090E03080D02070C01060B};
    vecs[1] = '{1'b0, 128'hD42711AEE0BF98F1B8B45DE51E415230, 128'hD4BF5D30E0B452AEB84111F11E2798E5};
    vecs[2] = '{1'b1, 128'hD4BF5D30E0B452AEB84111F11E2798E5, 128'hD42711AEE0BF98F1B8B45DE51E415230};
    vecs[3] = '{1'b1, 128'h00050A0F04090E03080D02070C01060B, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[4] = '{1'b1, 128'h000102030405060708090A0B0C0D0E0F, 128'h000D0A0704010E0B0805020F0C090603};
    vecs[5] = '{1'b0, 128'h0000000000FF00000000000000000000, 128'h00FF0000000000000000000000000000};
    vecs[6] = '{1'b1, 128'h0000000000FF00000000000000000000, 128'h000000000000000000FF000000000000};
    for (int i = 0; i < 20; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 6; i++)  blk8[i] = {$urandom, $urandom, $urandom, $urandom,
                                            $urandom, $urandom, $urandom, $urandom};

    rst_n = 1'b0;
    {a_flush, a_in_valid, a_in_inv} = '0; a_out_ready = 1'b1; a_din = '0;
    {b_flush, b_in_valid, b_in_inv} = '0; b_out_ready = 1'b1; b_din = '0;
    {c_flush, c_in_valid, c_in_inv} = '0; c_out_ready = 1'b1; c_din = '0;
    {f_flush, f_in_valid, f_in_inv} = '0; i_in_inv = 1'b1; i_out_ready = 1'b1; f_din = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(a_out_valid), 256'(0));
    check("rst_in_ready",  256'(a_in_ready),  256'(0));
    check("rst_occ",       256'(a_occ),       256'(0));
    check("rst_data_out",  256'(a_dout),      256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_in_ready", 256'(a_in_ready), 256'(1));

    // ---- table: back-to-back through STAGES=1 ----
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_inv = vecs[i].inv; a_din = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 256'(a_out_valid), 256'(1));
      check($sformatf("vec%0d_data", i),  256'(a_dout),      256'(vecs[i].exp));
      check($sformatf("vec%0d_occ", i),   256'(a_occ),       256'(1));
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", 256'(a_out_valid), 256'(0));
    check("drain_occ",   256'(a_occ),       256'(0));

    // ---- stall: output held, input refused, then released ----
    @(negedge clk);
    a_in_valid = 1'b1; a_in_inv = vecs[0].inv; a_din = vecs[0].din; a_out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall_first", 256'(a_dout), 256'(vecs[0].exp));
    @(negedge clk);
    a_in_inv = vecs[1].inv; a_din = vecs[1].din;
    #1;
    check("stall_in_ready", 256'(a_in_ready), 256'(0));
    @(posedge clk);
    #1;
    check("stall_hold_data",  256'(a_dout),      256'(vecs[0].exp));
    check("stall_hold_valid", 256'(a_out_valid), 256'(1));
    @(negedge clk);
    a_out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 256'(a_in_ready), 256'(1));
    @(posedge clk);
    #1;
    check("unstall_data", 256'(a_dout), 256'(vecs[1].exp));
    @(negedge clk);
    a_in_valid = 1'b0;

    // ---- latency with STAGES=3 ----
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_din = vecs[0].din;
    @(posedge clk);
    #1;
    lat = 1;
    @(negedge clk);
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lat3_cycles", 256'(lat),    256'(3));
    check("lat3_data",   256'(b_dout), 256'(vecs[0].exp));
    @(posedge clk);
    #1;

    // ---- 20 blocks, random out_ready, alternating mode ----
    sent = 0; recv = 0; inflight = 0; cyc = 0;
    while (recv < 20 && cyc < 600) begin
      @(negedge clk);
      b_in_valid  = (sent < 20);
      b_in_inv    = (sent % 2) == 1;
      b_din       = blk[sent % 20];
      b_out_ready = 1'($urandom_range(0, 1));
      #1;
      fin  = b_in_valid && b_in_ready;
      fout = b_out_valid && b_out_ready;
      if (fout) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_block", 256'(1), 256'(0));
        end else begin
          e4 = exp_q.pop_front();
          check($sformatf("stream_blk%0d", recv), 256'(b_dout), 256'(e4));
        end
        recv++;
      end
      if (fin) begin
        exp_q.push_back(model4(b_in_inv, b_din));
        sent++;
      end
      @(posedge clk);
      #1;
      inflight = inflight + int'(fin) - int'(fout);
      check("stream_occ", 256'(b_occ), 256'(inflight));
      cyc++;
    end
    b_in_valid = 1'b0;
    check("stream_recv", 256'(recv), 256'(20));
    check("stream_sent", 256'(sent), 256'(20));
    @(negedge clk);
    b_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stream_no_dup", 256'(b_out_valid), 256'(0));

    // ---- NB=8 forward then inverse ----
    sent = 0; recv = 0; cyc = 0;
    while (recv < 6 && cyc < 300) begin
      @(negedge clk);
      f_in_valid  = (sent < 6);
      f_din       = blk8[sent % 6];
      i_out_ready = 1'($urandom_range(0, 1));
      #1;
      fin  = f_in_valid && f_in_ready;
      fmid = f_out_valid && i_in_ready;
      fout = i_out_valid && i_out_ready;
      if (fmid) begin
        if (src_q.size() == 0) begin
          check("nb8_fwd_extra", 256'(1), 256'(0));
        end else begin
          e8 = src_q.pop_front();
          check("nb8_fwd_model", f_dout, model(8, 1'b0, e8));
          check("nb8_row2_shift3", 256'(f_dout[8*2 +: 8]), 256'(e8[8*(4*3 + 2) +: 8]));
          check("nb8_row3_shift4", 256'(f_dout[8*3 +: 8]), 256'(e8[8*(4*4 + 3) +: 8]));
        end
      end
      if (fout) begin
        if (orig_q.size() == 0) begin
          check("nb8_inv_extra", 256'(1), 256'(0));
        end else begin
          e8 = orig_q.pop_front();
          check($sformatf("nb8_roundtrip%0d", recv), i_dout, e8);
        end
        recv++;
      end
      if (fin) begin
        src_q.push_back(f_din);
        orig_q.push_back(f_din);
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    f_in_valid = 1'b0;
    check("nb8_recv", 256'(recv), 256'(6));

    // ---- flush with full STAGES=2 pipe and in_valid high ----
    @(negedge clk);
    c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_inv = 1'b0; c_din = blk[0];
    @(posedge clk);
    @(negedge clk);
    c_din = blk[1];
    @(posedge clk);
    #1;
    check("flush_pre_occ", 256'(c_occ), 256'(2));
    @(negedge clk);
    c_din = blk[2]; c_out_ready = 1'b1;
    #1;
    check("flush_ready_noflush", 256'(c_in_ready), 256'(1));
    c_flush = 1'b1;
    #1;
    check("flush_in_ready", 256'(c_in_ready), 256'(0));
    @(posedge clk);
    #1;
    check("flush_out_valid", 256'(c_out_valid), 256'(0));
    check("flush_occ",       256'(c_occ),       256'(0));
    @(negedge clk);
    c_flush = 1'b0; c_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush_not_accepted", 256'(c_occ), 256'(0));

    // ---- async reset with 2 blocks in flight ----
    @(negedge clk);
    c_out_ready = 1'b0; c_in_valid = 1'b1; c_din = blk[3];
    @(posedge clk);
    @(negedge clk);
    c_din = blk[4];
    @(posedge clk);
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 256'(c_out_valid), 256'(1));
    check("pre_rst_data",  256'(c_dout),      256'(model4(1'b0, blk[3])));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 256'(c_out_valid), 256'(0));
    check("async_rst_data",  256'(c_dout),      256'(0));
    check("async_rst_occ",   256'(c_occ),       256'(0));
    check("async_rst_ready", 256'(c_in_ready),  256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 256'(c_in_ready),  256'(1));
    check("post_rst_valid", 256'(c_out_valid), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (legal 4, 6, 8; any other value SHALL fail elaboration).
REQ-002 The block SHALL have parameter STAGES, default 1, meaning pipeline register stages (legal 1..4).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock (all state updates on rising edge).
REQ-004 The block SHALL have port rst_n, input, 1, meaning the reset (asynchronous, active-low).
REQ-005 The block SHALL have port flush, input, 1, meaning a synchronous clear of all in-flight blocks.
REQ-006 The block SHALL have port in_valid, input, 1, meaning input block present.
REQ-007 The block SHALL have port in_ready, output, 1, meaning input accepted this cycle when high with in_valid.
REQ-008 The block SHALL have port in_inv, input, 1, meaning per-block mode (0 = ShiftRows, 1 = InvShiftRows).
REQ-009 The block SHALL have port data_in, input, [0:32*NB-1], meaning state, byte k = data_in[8k+:8], row k%4, column k/4.
REQ-010 The block SHALL have port out_valid, output, 1, meaning output block present.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts.
REQ-012 The block SHALL have port data_out, output, [0:32*NB-1], meaning permuted state, same byte mapping as data_in.
REQ-013 The block SHALL have port occupancy, output, $clog2(STAGES+1), meaning count of valid stages.

Function
REQ-014 Row offsets SHALL be C(r) = {0,1,2,3} for NB 4 and 6, and {0,1,3,4} for NB 8 (Rijndael).
REQ-015 Forward mode SHALL give out[r][c] = in[r][(c + C(r)) mod NB]; inverse SHALL give out[r][(c + C(r)) mod NB] = in[r][c].
REQ-016 The permutation SHALL be applied combinationally before stage 1; in_inv SHALL be captured with its block and never affect other blocks.
REQ-017 Each stage SHALL hold a valid bit and a 32*NB-bit data register; data SHALL be unchanged while its stage stalls.
REQ-018 Stage i SHALL load when its downstream side is empty or advancing; the last stage advances on out_valid and out_ready.
REQ-019 in_ready SHALL equal (stage 1 empty or advancing) and not flush; ready MAY propagate combinationally through the stages.
REQ-020 Latency SHALL be STAGES cycles from acceptance to out_valid with no stall; throughput SHALL be one block per cycle at full flow.
REQ-021 out_valid and data_out SHALL be driven from the last stage registers only (no combinational path from data_in).
REQ-022 Backpressure SHALL lose no block and duplicate no block; order SHALL be preserved.
REQ-023 flush SHALL clear all valid bits on the next edge, SHALL win over a simultaneous in_valid (block not accepted), and SHALL drop a block presented with out_ready that cycle unless the transfer already completed that edge (out_valid and out_ready high means completed).
REQ-024 occupancy SHALL equal the number of set stage valid bits, updated each edge, 0 after flush.

Reset
REQ-025 rst_n low SHALL asynchronously clear all valid bits, forcing out_valid = 0, occupancy = 0 and in_ready = 0 while reset is asserted.
REQ-026 data registers SHALL reset to all zeros; data_out SHALL read 0 after reset.
REQ-027 Reset asserted mid-transfer SHALL discard all in-flight blocks; in_ready SHALL rise in the first cycle after rst_n deasserts.

Structure
REQ-028 Shared package aes_pkg SHALL hold the byte typedef, the legal-NB check and the row-offset function C(NB, r).
REQ-029 The permutation SHALL be a combinational sub-module shift_rows_perm (parameter NB, ports inv, data_in, data_out); the pipeline and handshake SHALL live in shift_rows_pipe.

Verification
REQ-030 NB=4, in_inv=0, data_in = 000102...0F -> data_out = 00050A0F04090E03080D02070C01060B after STAGES cycles.
REQ-031 NB=4, FIPS-197 B round 1, data_in = D42711AEE0BF98F1B8B45DE51E415230 -> data_out = D4BF5D30E0B452AEB84111F11E2798E5; in_inv=1 on that output returns the input.
REQ-032 NB=8, random blocks, forward then inverse through two instances -> data equal to input; row 2 shift 3 and row 3 shift 4 checked against the model.
REQ-033 STAGES=3, 20 back-to-back blocks with out_ready toggled randomly -> all 20 out in order, none lost or duplicated, occupancy never exceeds 3.
REQ-034 STAGES=2, pipeline full, flush and in_valid high together -> in_ready=0, next cycle out_valid=0 and occupancy=0.
REQ-035 rst_n pulsed low with 2 blocks in flight -> out_valid=0 and data_out=0 immediately (asynchronously), in_ready=1 the cycle after release.
